// File: rtl/lut_eval_pkg.sv
// Shared types and constants for the programmable LUT evaluator.
// Optional build macro used by this slice: CFG_PARITY_EN.
package lut_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfgState_t;

    localparam logic [15:0] TT_PAR4 = 16'h9669;
    localparam logic [15:0] TT_AND4 = 16'h8000;
    localparam logic [15:0] TT_OR4  = 16'hFFFE;

    function automatic int unsigned ttDepth(input int unsigned nIn);
        return 32'd1 << nIn;
    endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Bit-serial truth-table loader: FSM, bit counter, shadow register and commit strobe.
// With CFG_PARITY_EN defined, a trailing parity bit gates the commit and drives err.
module lut_cfg_loader
    import lut_eval_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned N_CH = 8,
    parameter int unsigned CH_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfgStart,
    input  logic [CH_W-1:0]             cfgCh,
    input  logic                        cfgBitVld,
    input  logic                        cfgBit,
    output logic                        busy,
    output logic                        done,
`ifdef CFG_PARITY_EN
    output logic                        err,
`endif
    output logic                        commit,
    output logic [CH_W-1:0]             commitCh,
    output logic [ttDepth(N_IN)-1:0]    commitTable
);

    localparam int unsigned TT    = ttDepth(N_IN);
    localparam int unsigned CNT_W = N_IN + 1;
`ifdef CFG_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TT);
`else
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TT - 1);
`endif
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(N_CH);

    cfgState_t         state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic [TT-1:0]     shadow, shadowNext;
    logic [CH_W-1:0]   chReg, chNext;
`ifdef CFG_PARITY_EN
    logic              parBit, parBitNext;
    logic              parOk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            chReg  <= '0;
`ifdef CFG_PARITY_EN
            parBit <= 1'b0;
`endif
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            shadow <= shadowNext;
            chReg  <= chNext;
`ifdef CFG_PARITY_EN
            parBit <= parBitNext;
`endif
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        shadowNext = shadow;
        chNext     = chReg;
`ifdef CFG_PARITY_EN
        parBitNext = parBit;
`endif
        case (state)
            IDLE: begin
                if (cfgStart && ({1'b0, cfgCh} < CH_LIMIT)) begin
                    stateNext  = LOAD;
                    cntNext    = '0;
                    shadowNext = '0;
                    chNext     = cfgCh;
`ifdef CFG_PARITY_EN
                    parBitNext = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (cfgBitVld) begin
`ifdef CFG_PARITY_EN
                    // Index TT is the parity slot, one past the table bits.
                    if (cnt == CNT_W'(TT))
                        parBitNext = cfgBit;
                    else
                        shadowNext[cnt[N_IN-1:0]] = cfgBit;
`else
                    shadowNext[cnt[N_IN-1:0]] = cfgBit;
`endif
                    cntNext = cnt + CNT_W'(1);
                    if (cnt == LAST_BIT)
                        stateNext = COMMIT;
                end
            end
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        commitCh    = chReg;
        commitTable = shadow;
`ifdef CFG_PARITY_EN
        parOk  = !((^shadow) ^ parBit);
        commit = (state == COMMIT) && parOk;
        err    = (state == COMMIT) && !parOk;
`else
        commit = (state == COMMIT);
`endif
        done = commit;
    end

endmodule

// File: rtl/lut_eval_seq.sv
// Programmable N_CH x N_IN truth-table evaluator with a registered valid/ready output.
// Build macro CFG_PARITY_EN adds a parity-checked load and the cfg_err port.
module lut_eval_seq
    import lut_eval_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned N_CH = 8,
    parameter int unsigned CH_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_bit_vld,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [N_CH-1:0] out_vec
`ifdef CFG_PARITY_EN
    ,
    output logic            cfg_err
`endif
);

    localparam int unsigned TT = ttDepth(N_IN);

    logic [TT-1:0]   tables [N_CH];
    logic            commit;
    logic [CH_W-1:0] commitCh;
    logic [TT-1:0]   commitTable;
    logic [N_CH-1:0] evalVec;
    logic            inXfer;

    lut_cfg_loader #(
        .N_IN(N_IN),
        .N_CH(N_CH),
        .CH_W(CH_W)
    ) uLoader (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfgStart    (cfg_start),
        .cfgCh       (cfg_ch),
        .cfgBitVld   (cfg_bit_vld),
        .cfgBit      (cfg_bit),
        .busy        (cfg_busy),
        .done        (cfg_done),
`ifdef CFG_PARITY_EN
        .err         (cfg_err),
`endif
        .commit      (commit),
        .commitCh    (commitCh),
        .commitTable (commitTable)
    );

    // Inputs stall while a load is in flight so no result mixes old and new tables.
    always_comb begin
        in_rdy = !cfg_busy && (!out_vld || out_rdy);
        inXfer = in_vld && in_rdy;
    end

    always_comb begin
        evalVec = '0;
        for (int unsigned k = 0; k < N_CH; k++)
            evalVec[k] = tables[k][in_vec];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_CH; k++)
                tables[k] <= '0;
        end else if (commit) begin
            for (int unsigned k = 0; k < N_CH; k++)
                if (commitCh == CH_W'(k))
                    tables[k] <= commitTable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_vec <= '0;
        end else if (inXfer) begin
            out_vld <= 1'b1;
            out_vec <= evalVec;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lut_eval_seq.sv
// Directed self-checking bench for lut_eval_seq (default parameters).
// Parity-load steps are compiled in when CFG_PARITY_EN is defined.
module tb_lut_eval_seq;
    import lut_eval_pkg::*;

    localparam int unsigned N_IN = 4;
    localparam int unsigned N_CH = 8;
    localparam int unsigned CH_W = 3;
`ifdef CFG_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_start, cfg_bit_vld, cfg_bit;
    logic [CH_W-1:0] cfg_ch;
    logic            cfg_busy, cfg_done;
    logic            in_vld, in_rdy, out_vld, out_rdy;
    logic [N_IN-1:0] in_vec;
    logic [N_CH-1:0] out_vec;
`ifdef CFG_PARITY_EN
    logic            cfg_err;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    lut_eval_seq #(
        .N_IN(N_IN),
        .N_CH(N_CH),
        .CH_W(CH_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_ch      (cfg_ch),
        .cfg_bit_vld (cfg_bit_vld),
        .cfg_bit     (cfg_bit),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_vec      (in_vec),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_vec     (out_vec)
`ifdef CFG_PARITY_EN
        ,
        .cfg_err     (cfg_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // word[16] is the parity bit, only shifted in when the parity build is active.
    task automatic loadTable(input logic [CH_W-1:0] ch, input logic [16:0] word);
        cfg_start = 1'b1;
        cfg_ch    = ch;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            cfg_bit_vld = 1'b1;
            cfg_bit     = word[i];
            tick();
        end
        cfg_bit_vld = 1'b0;
        cfg_bit     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_ch = '0; cfg_bit_vld = 1'b0; cfg_bit = 1'b0;
        in_vld = 1'b0; in_vec = '0; out_rdy = 1'b0;
        #12;
        check("rst_out_vld", 32'(out_vld), 32'h0);
        check("rst_out_vec", 32'(out_vec), 32'h0);
        check("rst_busy", 32'(cfg_busy), 32'h0);
        check("rst_done", 32'(cfg_done), 32'h0);
`ifdef CFG_PARITY_EN
        check("rst_err", 32'(cfg_err), 32'h0);
`endif
        rst_n = 1'b1;
        tick();
        #1 check("rst_in_rdy", 32'(in_rdy), 32'h1);

        // Empty tables evaluate to zero with latency 1.
        in_vld = 1'b1; in_vec = 4'hF; out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        check("empty_vld", 32'(out_vld), 32'h1);
        check("empty_vec", 32'(out_vec), 32'h00);
        tick();
        check("drain_vld", 32'(out_vld), 32'h0);

        loadTable(3'd0, {1'b0, TT_PAR4});
        check("ld0_done", 32'(cfg_done), 32'h1);
        check("ld0_busy", 32'(cfg_busy), 32'h1);
        #1 check("ld0_in_rdy", 32'(in_rdy), 32'h0);
`ifdef CFG_PARITY_EN
        check("ld0_err", 32'(cfg_err), 32'h0);
`endif
        tick();
        check("ld0_done_off", 32'(cfg_done), 32'h0);
        check("ld0_busy_off", 32'(cfg_busy), 32'h0);
        loadTable(3'd1, {1'b1, TT_AND4});
        check("ld1_done", 32'(cfg_done), 32'h1);
        tick();
        check("ld1_done_off", 32'(cfg_done), 32'h0);

        in_vld = 1'b1; in_vec = 4'h3; out_rdy = 1'b1;
        tick();
        check("eval_3", 32'(out_vec), 32'h01);
        in_vec = 4'hF;
        tick();
        check("eval_F", 32'(out_vec), 32'h03);

        // Back-pressure: result F pending, new input must not be taken.
        out_rdy = 1'b0; in_vec = 4'h3;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_in_rdy", 32'(in_rdy), 32'h0);
            tick();
            check("bp_vld", 32'(out_vld), 32'h1);
            check("bp_vec", 32'(out_vec), 32'h03);
        end
        out_rdy = 1'b1; in_vec = 4'h0;
        #1 check("bp_release_rdy", 32'(in_rdy), 32'h1);
        tick();
        check("tp_0", 32'(out_vec), 32'h01);
        in_vec = 4'h1;
        tick();
        check("tp_1", 32'(out_vec), 32'h00);
        in_vec = 4'hF;
        tick();
        check("tp_F", 32'(out_vec), 32'h03);
        in_vld = 1'b0;
        tick();
        check("tp_drain", 32'(out_vld), 32'h0);

        // Load start coincides with an input transfer; stray start mid-load is ignored.
        cfg_start = 1'b1; cfg_ch = 3'd2; in_vld = 1'b1; in_vec = 4'hF;
        #1 check("par_start_rdy", 32'(in_rdy), 32'h1);
        tick();
        cfg_start = 1'b0;
        check("old_table_vec", 32'(out_vec), 32'h03);
        #1 check("load_in_rdy", 32'(in_rdy), 32'h0);
        for (int i = 0; i < NBITS; i++) begin
            cfg_start   = (i == 4);
            cfg_ch      = (i == 4) ? 3'd5 : 3'd2;
            cfg_bit_vld = 1'b1;
            cfg_bit     = (i == 15 || i == 16);
            tick();
        end
        cfg_start = 1'b0; cfg_bit_vld = 1'b0; cfg_bit = 1'b0;
        check("ld2_done", 32'(cfg_done), 32'h1);
        check("ld2_out_vld", 32'(out_vld), 32'h0);
        tick();
        #1 check("post_commit_rdy", 32'(in_rdy), 32'h1);
        tick();
        check("new_table_F", 32'(out_vec), 32'h07);
        in_vec = 4'h3;
        tick();
        check("new_table_3", 32'(out_vec), 32'h01);

        // A pending result survives a later commit.
        in_vec = 4'hF;
        tick();
        out_rdy = 1'b0; in_vld = 1'b0;
        check("pend_vec", 32'(out_vec), 32'h07);
        loadTable(3'd0, 17'h0);
        tick();
        check("pend_hold_vld", 32'(out_vld), 32'h1);
        check("pend_hold_vec", 32'(out_vec), 32'h07);
        out_rdy = 1'b1; in_vld = 1'b1; in_vec = 4'hF;
        tick();
        check("ch0_cleared", 32'(out_vec), 32'h06);
        in_vld = 1'b0;
        tick();

`ifdef CFG_PARITY_EN
        loadTable(3'd0, {1'b0, TT_AND4});
        check("perr_err", 32'(cfg_err), 32'h1);
        check("perr_done", 32'(cfg_done), 32'h0);
        tick();
        check("perr_err_off", 32'(cfg_err), 32'h0);
        check("perr_busy", 32'(cfg_busy), 32'h0);
        in_vld = 1'b1; in_vec = 4'hF;
        tick();
        in_vld = 1'b0;
        check("perr_unchanged", 32'(out_vec), 32'h06);
        loadTable(3'd0, {1'b1, TT_AND4});
        check("pok_done", 32'(cfg_done), 32'h1);
        check("pok_err", 32'(cfg_err), 32'h0);
        tick();
        in_vld = 1'b1; in_vec = 4'hF;
        tick();
        in_vld = 1'b0;
        check("pok_commit", 32'(out_vec), 32'h07);
        tick();
`endif

        // Reset arrives while bit 7 of a ch3 load is on the wire.
        cfg_start = 1'b1; cfg_ch = 3'd3;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_bit_vld = 1'b1;
            cfg_bit     = TT_OR4[i];
            tick();
        end
        check("mid_load_busy", 32'(cfg_busy), 32'h1);
        cfg_bit = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(cfg_busy), 32'h0);
        check("arst_out_vec", 32'(out_vec), 32'h0);
        rst_n = 1'b1; cfg_bit_vld = 1'b0; cfg_bit = 1'b0;
        out_rdy = 1'b1; in_vld = 1'b1;
        for (int v = 0; v < 16; v++) begin
            in_vec = 4'(v);
            tick();
            check("arst_eval", 32'(out_vec), 32'h0);
        end
        in_vld = 1'b0;
        tick();
        check("arst_idle", 32'(cfg_busy), 32'h0);
        check("arst_done", 32'(cfg_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/lut_eval_seq.md
Name: lut_eval_seq

Overview:
- Parametrised, programmable successor to the fixed sum-of-products gate blocks.
- Holds N_CH run-time loadable truth tables, each a function of N_IN inputs. It evaluates all channels on each accepted input vector and returns the result through a registered valid/ready output stage.
- Tables are loaded bit-serially by a small FSM and committed atomically. It sits between the stimulus source and the result checker in the lab datapath.

Parameters:
- N_IN, 4, number of function inputs; table depth is TT = 2**N_IN bits; legal range 2..6.
- N_CH, 8, number of independent output functions (channels); legal range 1..16.
- CH_W, 3, width of the channel index; must satisfy 2**CH_W ≥ N_CH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle pulse; begins loading channel cfg_ch.
- cfg_ch  in  CH_W  target channel, sampled with cfg_start.
- cfg_bit_vld  in  1  a table bit is present on cfg_bit.
- cfg_bit  in  1  serial table bit, LSB (index 0) first.
- cfg_busy  out  1  load in progress.
- cfg_done  out  1  one-cycle pulse on commit.
- in_vld  in  1  input vector valid.
- in_rdy  out  1  block accepts an input vector.
- in_vec  in  N_IN  function inputs; bit N_IN-1 is the most significant (A).
- out_vld  out  1  result valid.
- out_rdy  in  1  downstream accepts the result.
- out_vec  out  N_CH  out_vec[k] = table_k[in_vec].

Behaviour:
- Reset (asynchronous, active-low): all tables = 0, out_vec = 0, out_vld = 0, cfg_busy = 0, cfg_done = 0, FSM = IDLE, bit counter = 0.
- FSM states:
  - IDLE: cfg_start with cfg_ch < N_CH → LOAD; clear the shadow register and the counter. cfg_start with cfg_ch ≥ N_CH is ignored.
  - LOAD: each cycle with cfg_bit_vld high, write shadow[cnt] = cfg_bit and increment cnt. On the bit where cnt = TT-1 → COMMIT. cfg_start during LOAD is ignored.
  - COMMIT: copy the shadow into table[cfg_ch] in one cycle, pulse cfg_done, → IDLE.
- cfg_busy = 1 in LOAD and COMMIT.
- in_rdy = (FSM == IDLE) && (!out_vld || out_rdy). Evaluation stalls during a load so that no result mixes old and new tables.
- Handshake: a transfer occurs when vld && rdy. On an input transfer, out_vec is registered on the next clock edge, giving latency 1. out_vld rises on that edge.
- out_vld and out_vec hold stable while out_vld && !out_rdy.
- Simultaneous output drain and new input accept gives full throughput of 1 vector/cycle.
- cfg_start arriving in the same cycle as an input transfer: the input is evaluated with the old tables; LOAD starts in parallel.
- A pending output is unaffected by a later commit.
- Asynchronous reset mid-load discards the shadow register; the tables return to 0.

Optional Feature:
- CFG_PARITY_EN:
  - When defined: after the TT table bits, LOAD expects one extra parity bit on cfg_bit with cfg_bit_vld. If the XOR of the table bits and the parity bit is 1 (odd total), the table is not committed. An extra output port cfg_err (1 bit, reset 0) pulses for one cycle instead of cfg_done, and the FSM returns to IDLE.
  - When undefined: no parity bit, no cfg_err port; behaviour as above.

Decomposition:
- Shared package lut_eval_pkg holds:
  - the FSM state enum (IDLE, LOAD, COMMIT);
  - a function computing TT from N_IN;
  - localparam default table constants TT_PAR4 = 16'h9669, TT_AND4 = 16'h8000, TT_OR4 = 16'hFFFE.
- One sub-module, lut_cfg_loader, contains the FSM, counter, shadow register and optional parity check. It outputs a commit strobe, channel index and table word.
- The table array and output stage remain in the top module.

Test Plan:
- Reset, then send in_vec = 4'hF with out_rdy = 1 → out_vld after 1 cycle, out_vec = 8'h00.
- Load ch0 = 16'h9669 and ch1 = 16'h8000 → cfg_done pulses once each. Then in_vec 4'h3 gives out_vec[1:0] = 2'b01, and 4'hF gives 2'b11.
- Hold out_rdy = 0 with one result pending → in_rdy = 0 and out_vec stable for 5 cycles. Raise out_rdy with in_vld held → one result per cycle.
- Pulse cfg_start for ch2 while in_vld = 1 → in_rdy drops the next cycle. Inputs accepted before the commit use the old table; inputs after it use the new one.
- Assert rst_n low at bit 7 of a ch3 load of 16'hFFFE → after reset, ch3 evaluates 0 for every in_vec and FSM = IDLE.
- CFG_PARITY_EN: load 16'h8000 with parity bit 0 → cfg_err pulses and ch0 is unchanged. With parity bit 1 → cfg_done pulses and the table is committed.
